// File: rtl/bist_signature_analyzer_if.sv
// Strobe/response bundle between the BIST controller side and the signature analyzer.
// The master drives the controller strobes and CUT response; the slave returns signature and verdict.
interface bist_signature_analyzer_if #(
    parameter int W  = 16,
    parameter int CW = 8
);
    logic          running;
    logic          out;
    logic          finish;
    logic [W-1:0]  cut_resp;
    logic [W-1:0]  signature;
    logic [CW-1:0] capt_cnt;
    logic          busy;
    logic          done;
    logic          pass;
    logic          fail;

    modport master (
        output running, out, finish, cut_resp,
        input  signature, capt_cnt, busy, done, pass, fail
    );

    modport slave (
        input  running, out, finish, cut_resp,
        output signature, capt_cnt, busy, done, pass, fail
    );
endinterface

// File: rtl/bist_signature_analyzer.sv
// MISR-based response compactor: captures CUT responses on OUT, checks the signature
// and capture count against golden values on FINISH, and holds the verdict until the next run.
module bist_signature_analyzer #(
    parameter int           W        = 16,
    parameter logic [W-1:0] POLY     = 16'h1021,
    parameter logic [W-1:0] SEED_VAL = 16'h0000,
    parameter logic [W-1:0] GOLDEN   = 16'h0000,
    parameter int           EXP_CNT  = 144,
    parameter int           CW       = 8
) (
    input logic                    clk_i,
    input logic                    rst_ni,
    bist_signature_analyzer_if.slave bus
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPACT = 2'd1;
    localparam logic [1:0] S_CHECK   = 2'd2;
    localparam logic [1:0] S_REPORT  = 2'd3;

    localparam logic [CW-1:0] EXP = CW'(EXP_CNT);

    logic [1:0]    state_q, state_d;
    logic          run_q;
    logic [W-1:0]  sig_q, sig_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic          fail_q, fail_d;
    logic          rs;
    logic          match;
    logic [W-1:0]  sig_next;

    assign rs       = bus.running & ~run_q;
    assign match    = (sig_q == GOLDEN) && (cnt_q == EXP);
    assign sig_next = {sig_q[W-2:0], 1'b0} ^ (sig_q[W-1] ? POLY : '0) ^ bus.cut_resp;

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        case (state_q)
            S_COMPACT: begin
                if (rs) begin
                    sig_d = SEED_VAL;
                    cnt_d = '0;
                end else if (bus.finish) begin
                    state_d = S_CHECK;
                end else if (bus.out) begin
                    sig_d = sig_next;
                    if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                end
            end
            // CHECK always lasts exactly one cycle; a run start here is not honoured.
            S_CHECK: begin
                state_d = S_REPORT;
                done_d  = 1'b1;
                pass_d  = match;
                fail_d  = ~match;
            end
            default: begin
                if (rs) begin
                    state_d = S_COMPACT;
                    sig_d   = SEED_VAL;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                end
            end
        endcase
        busy_d = (state_d == S_COMPACT) || (state_d == S_CHECK);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            run_q   <= 1'b0;
            sig_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= bus.running;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
        end
    end

    assign bus.signature = sig_q;
    assign bus.capt_cnt  = cnt_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.fail      = fail_q;
endmodule

// File: tb/tb_bist_signature_analyzer.sv
// Directed bench for bist_signature_analyzer: MISR arithmetic, golden/fault runs,
// FINISH priority, count saturation, reset mid-run and restart from REPORT.
module tb_bist_signature_analyzer;
    localparam int W  = 16;
    localparam int CW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    bist_signature_analyzer_if #(.W(W), .CW(CW)) bus ();

    bist_signature_analyzer #(
        .W(W), .POLY(16'h1021), .SEED_VAL(16'h0000), .GOLDEN(16'h0000),
        .EXP_CNT(144), .CW(CW)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Controller-like run: rise, n captures with an OUT=0 gap every 9, FINISH two cycles after last OUT.
    task automatic do_run(input int n, input int fault_at, input logic out_on_fin);
        bus.running = 1'b0; bus.out = 1'b0; bus.finish = 1'b0; bus.cut_resp = '0;
        step();
        bus.running = 1'b1;
        step();
        chk("run_start_busy", 32'(bus.busy), 32'd1);
        chk("run_start_cnt", 32'(bus.capt_cnt), 32'd0);
        for (int i = 1; i <= n; i++) begin
            bus.out = 1'b1;
            bus.cut_resp = (i == fault_at) ? 16'h0004 : 16'h0000;
            step();
            if ((i % 9) == 0 && i < n) begin
                bus.out = 1'b0;
                bus.cut_resp = 16'hDEAD;
                step();
            end
        end
        bus.out = 1'b0; bus.cut_resp = '0;
        step();
        bus.finish = 1'b1; bus.out = out_on_fin; bus.cut_resp = 16'hFFFF;
        step();
        chk("check_busy", 32'(bus.busy), 32'd1);
        chk("check_done", 32'(bus.done), 32'd0);
        bus.finish = 1'b0; bus.out = 1'b0; bus.cut_resp = '0;
        step();
        chk("report_done", 32'(bus.done), 32'd1);
        chk("report_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        bus.running = 1'b0; bus.out = 1'b0; bus.finish = 1'b0; bus.cut_resp = '0;

        // reset with random inputs
        for (int i = 0; i < 3; i++) begin
            bus.running  = 1'($urandom);
            bus.out      = 1'($urandom);
            bus.finish   = 1'($urandom);
            bus.cut_resp = 16'($urandom);
            step();
        end
        chk("rst_sig", 32'(bus.signature), 32'd0);
        chk("rst_cnt", 32'(bus.capt_cnt), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_pass", 32'(bus.pass), 32'd0);
        chk("rst_fail", 32'(bus.fail), 32'd0);

        // FINISH/OUT in IDLE ignored
        bus.running = 1'b0; bus.out = 1'b1; bus.finish = 1'b1; bus.cut_resp = 16'h1234;
        rst_n = 1'b1;
        step();
        chk("idle_finish_done", 32'(bus.done), 32'd0);
        chk("idle_out_sig", 32'(bus.signature), 32'd0);
        bus.out = 1'b0; bus.finish = 1'b0; bus.cut_resp = '0;

        // MISR arithmetic; OUT in the rs cycle is ignored
        bus.running = 1'b1; bus.out = 1'b1; bus.cut_resp = 16'h5555;
        step();
        chk("rs_busy", 32'(bus.busy), 32'd1);
        chk("rs_out_ignored", 32'(bus.signature), 32'd0);
        bus.cut_resp = 16'h0001;
        step();
        chk("misr_1", 32'(bus.signature), 32'h0001);
        bus.cut_resp = 16'h0000;
        step();
        chk("misr_2", 32'(bus.signature), 32'h0002);
        repeat (14) step();
        chk("misr_8000", 32'(bus.signature), 32'h8000);
        step();
        chk("misr_poly", 32'(bus.signature), 32'h1021);
        chk("misr_cnt", 32'(bus.capt_cnt), 32'd17);
        bus.out = 1'b0;

        // golden run (RUNNING fall+rise in COMPACT restarts)
        do_run(144, 0, 1'b0);
        chk("gold_cnt", 32'(bus.capt_cnt), 32'd144);
        chk("gold_sig", 32'(bus.signature), 32'd0);
        chk("gold_pass", 32'(bus.pass), 32'd1);
        chk("gold_fail", 32'(bus.fail), 32'd0);

        // fault at capture 50
        do_run(144, 50, 1'b0);
        chk("fault_sig_nz", 32'(bus.signature != 0), 32'd1);
        chk("fault_cnt", 32'(bus.capt_cnt), 32'd144);
        chk("fault_fail", 32'(bus.fail), 32'd1);
        chk("fault_pass", 32'(bus.pass), 32'd0);
        bus.running = 1'b0;
        repeat (3) step();
        chk("hold_done", 32'(bus.done), 32'd1);
        chk("hold_fail", 32'(bus.fail), 32'd1);

        // rise during REPORT: verdict cleared and re-seeded
        bus.running = 1'b1;
        step();
        chk("rerun_done", 32'(bus.done), 32'd0);
        chk("rerun_fail", 32'(bus.fail), 32'd0);
        chk("rerun_sig", 32'(bus.signature), 32'd0);
        chk("rerun_cnt", 32'(bus.capt_cnt), 32'd0);
        chk("rerun_busy", 32'(bus.busy), 32'd1);

        // short run, FINISH beats OUT
        do_run(100, 0, 1'b1);
        chk("short_cnt", 32'(bus.capt_cnt), 32'd100);
        chk("short_sig", 32'(bus.signature), 32'd0);
        chk("short_fail", 32'(bus.fail), 32'd1);
        chk("short_pass", 32'(bus.pass), 32'd0);

        // capture counter saturates
        do_run(260, 0, 1'b0);
        chk("sat_cnt", 32'(bus.capt_cnt), 32'd255);
        chk("sat_fail", 32'(bus.fail), 32'd1);

        // reset mid-run at capture 70
        bus.running = 1'b0;
        step();
        bus.running = 1'b1;
        step();
        for (int i = 1; i <= 70; i++) begin
            bus.out = 1'b1;
            bus.cut_resp = 16'(i * 3 + 1);
            step();
        end
        chk("mid_cnt", 32'(bus.capt_cnt), 32'd70);
        chk("mid_sig_nz", 32'(bus.signature != 0), 32'd1);
        rst_n = 1'b0;
        step();
        chk("mid_rst_sig", 32'(bus.signature), 32'd0);
        chk("mid_rst_cnt", 32'(bus.capt_cnt), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_done", 32'(bus.done), 32'd0);
        rst_n = 1'b1; bus.out = 1'b0; bus.cut_resp = '0;
        step();
        chk("rel_running_rs", 32'(bus.busy), 32'd1);

        do_run(144, 0, 1'b0);
        chk("regold_pass", 32'(bus.pass), 32'd1);
        chk("regold_fail", 32'(bus.fail), 32'd0);
        chk("regold_cnt", 32'(bus.capt_cnt), 32'd144);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bist_signature_analyzer.md
# bist_signature_analyzer

Response-side companion to the BIST controller. It watches the controller's RUNNING, OUT and FINISH strobes and compacts the circuit-under-test response into a multiple-input signature register (MISR) on every OUT cycle. It counts the captured vectors, and on FINISH compares the signature and the capture count against golden values. It then holds a PASS/FAIL verdict until the next BIST run begins.

## Interface
- W, 16, MISR and response width (≥2)
- POLY, 16'h1021, MISR feedback polynomial (bit i set = tap into bit i)
- SEED_VAL, 16'h0000, MISR value loaded at run start
- GOLDEN, 16'h0000, expected final signature
- EXP_CNT, 144, expected OUT-cycle count (N=9 × M=16)
- CW, 8, capture-counter width
- CLK  in  1  clock; all logic on rising edge
- RESET  in  1  synchronous, active-low reset
- RUNNING  in  1  controller RUNNING strobe
- OUT  in  1  controller OUT (capture enable)
- FINISH  in  1  controller FINISH (one-cycle pulse)
- CUT_RESP  in  W  CUT response word, sampled when capturing
- SIGNATURE  out  W  current MISR contents
- CAPT_CNT  out  CW  captured-vector count
- BUSY  out  1  high in COMPACT and CHECK
- DONE  out  1  verdict valid
- PASS  out  1  signature==GOLDEN and CAPT_CNT==EXP_CNT
- FAIL  out  1  verdict valid and not PASS

## Operation
- Registered copy run_q of RUNNING; run start rs = RUNNING & ~run_q.
- States:
  - IDLE: after reset.
  - COMPACT: accumulating.
  - CHECK: one cycle.
  - REPORT: verdict held.
- Transitions:
  - IDLE → COMPACT on rs.
  - REPORT → COMPACT on rs.
  - COMPACT → CHECK on FINISH.
  - CHECK → REPORT unconditionally.
  - rs in COMPACT restarts the run (re-seed, clear count, stay in COMPACT).
- On every rs:
  - SIGNATURE ← SEED_VAL.
  - CAPT_CNT ← 0.
  - DONE, PASS and FAIL ← 0.
  - OUT is ignored in the rs cycle.
- Capture condition: state==COMPACT, OUT=1, FINISH=0, not rs.
- Capture update: SIGNATURE ← {SIGNATURE[W-2:0],1'b0} ^ (SIGNATURE[W-1] ? POLY : 0) ^ CUT_RESP.
- CAPT_CNT increments on each capture and saturates at 2^CW−1 (no wrap).
- FINISH has priority over OUT in the same cycle; that cycle's CUT_RESP is discarded.
- FINISH outside COMPACT is ignored.
- OUT outside COMPACT is ignored.
- RUNNING falling edge has no effect; only FINISH ends compaction.
- In CHECK, comparison uses the final SIGNATURE and CAPT_CNT. The PASS/FAIL/DONE registers are loaded at the CHECK→REPORT edge.
- In REPORT, SIGNATURE and CAPT_CNT are frozen and DONE=1.
- Reset (RESET=0 at a rising edge, any state, including mid-run):
  - state ← IDLE.
  - SIGNATURE ← 0 (not SEED_VAL).
  - CAPT_CNT ← 0.
  - run_q ← 0.
  - BUSY, DONE, PASS, FAIL ← 0.
- If RUNNING is already high when reset releases, the next cycle sees rs and starts a run.

## Timing
- Capture latency: CUT_RESP at edge k appears in SIGNATURE after edge k.
- RUNNING rising sampled at edge k: COMPACT and re-seed valid after edge k. The first capture can be at edge k+1.
- FINISH sampled at edge k: CHECK after k, REPORT plus DONE/PASS/FAIL after k+1 (2-cycle latency).
- BUSY is registered with the state: 1 for COMPACT/CHECK, 0 for IDLE/REPORT.
- PASS and FAIL are mutually exclusive and never high while DONE=0.
- Verdict holds indefinitely until rs or reset.
- Nominal controller sequence: RUNNING rises, 144 OUT cycles interleaved with 15 OUT=0 wrap cycles (count_N==N), then FINISH 2 cycles after the last OUT.

## Test plan
- Reset check: hold RESET=0 for 3 cycles with random inputs → SIGNATURE=0, CAPT_CNT=0, BUSY=DONE=PASS=FAIL=0.
- MISR arithmetic (SEED_VAL=0):
  - capture 16'h0001 → 16'h0001.
  - then capture 0 → 16'h0002.
  - force to 16'h8000 via 15 zero captures after 1, then capture 0 → 16'h1021.
- Golden run (SEED_VAL=GOLDEN=0, CUT_RESP=0): full controller sequence of 144 captures → CAPT_CNT=144, DONE=PASS=1 two cycles after FINISH, FAIL=0.
- Fault detection: same run with CUT_RESP=16'h0004 at capture 50 only → SIGNATURE≠0, FAIL=1, PASS=0.
- Short run and priority:
  - FINISH after 100 captures with OUT=1 in the FINISH cycle → CAPT_CNT=100 (FINISH cycle not captured), FAIL=1.
- Reset and restart:
  - reset asserted mid-run at capture 70 → all outputs cleared, state IDLE.
  - new RUNNING rise then full golden run → PASS=1.
  - a further rise during REPORT clears DONE the next cycle and re-seeds.
